wb_spi_flash_ctrl: RTL and testbench
====================================

Name: wb_spi_flash_ctrl

Overview:
Pipelined Wishbone slave that drives the configuration SPI flash. It sits directly downstream of serial_wb_master, on the same 8-bit address / 8-bit data bus. It exposes a small register map: chip-select control, byte transmit/receive, status and clock divider. Host software sequences flash commands (JEDEC ID, write enable, page program, sector erase, read) byte by byte over UART through this block.

Parameters:
ADDR_BITS, 8, Wishbone address width; only the low 2 bits are decoded, upper bits must be zero for a hit.
CLKDIV_RESET, 1, reset value of the DIV register; SCK half-period = DIV+1 clk cycles.

Ports:
clk  input  1  system clock
sreset  input  1  synchronous reset, active-high
s_wb_addr  input  ADDR_BITS  register address
s_wb_dat_m2s  input  8  write data
s_wb_dat_s2m  output  8  read data, valid when s_wb_ack=1
s_wb_we  input  1  1=write
s_wb_sel  input  1  byte select; ignored, always treated as 1
s_wb_stb  input  1  strobe
s_wb_cyc  input  1  cycle
s_wb_ack  output  1  single-cycle acknowledge
s_wb_stall  output  1  pipeline stall
sck  output  1  SPI clock, mode 0
ss  output  1  flash chip select, active-low
miso  input  1  flash data out
mosi  output  1  flash data in

Behaviour:
- Register map:
  - 0x0 CTRL: bit0 = CS assert, so ss = ~CTRL[0]. R/W.
  - 0x1 DATA: a write starts an 8-bit transfer. A read returns the last received byte.
  - 0x2 STATUS: bit0 = busy. Read-only.
  - 0x3 DIV: 8 bits. R/W.
  - Any other address: reads 0, writes ignored, still acked.
- Reset values: ss=1, sck=0, mosi=0, s_wb_ack=0, s_wb_stall=0, s_wb_dat_s2m=0, CTRL=0, rx byte=0, DIV=CLKDIV_RESET.
- Accept: a request is accepted when cyc & stb & ~stall.
  - s_wb_ack=1 exactly one cycle after acceptance.
  - s_wb_dat_s2m is registered in the same cycle as ack.
  - Back-to-back accepts are allowed, one per cycle.
- Stall: s_wb_stall is asserted combinationally while busy and the presented request is a write to DATA, CTRL or DIV, or a read of DATA. STATUS reads are never stalled, so polling is allowed.
- cyc dropped with an accepted request outstanding: ack is suppressed; any transfer already started completes.
- State machine IDLE -> SHIFT -> IDLE:
  - IDLE, DATA write accepted: load tx shift register; mosi = bit7 in the next cycle; busy=1; half-period counter = 0; go to SHIFT.
  - SHIFT: every DIV+1 clk cycles sck toggles.
    - Rising edge: sample miso into the rx shift register LSB.
    - Falling edge: shift tx; mosi = next bit.
    - After the 8th falling edge: sck=0, rx byte committed, busy=0, go to IDLE.
  - Transfer length: 16*(DIV+1) clk cycles from the cycle after acceptance to busy=0.
  - MSB first. mosi holds bit0 after the transfer until the next load.
- DIV is sampled at transfer start only. DIV=0 gives sck = clk/2. DIV=255 is legal, with 8-bit counter wrap.
- ss is controlled only by CTRL. The block never toggles ss autonomously; multi-byte commands keep ss low across bytes.
- sreset mid-transfer: immediate abort; outputs return to reset values on the next cycle; no ack is issued.

Decomposition:
- Shared package wb_spi_flash_pkg:
  - register address localparams REG_CTRL, REG_DATA, REG_STATUS, REG_DIV
  - state enum typedef
  - STATUS bit index constant
- One sub-module spi_byte_shifter contains the counter, sck generation and tx/rx shift registers.
  - Inputs: start, tx_byte, div, miso.
  - Outputs: busy, rx_byte, sck, mosi.
- The Wishbone decode, register file and stall/ack logic stay in the top module.

Test Plan:
- Reset, then read each register -> CTRL=0x00, DATA=0x00, STATUS=0x00, DIV=CLKDIV_RESET, ss=1, sck=0; each read acked exactly 1 cycle after acceptance.
- Write CTRL=1, DIV=0, DATA=0x9F with a miso model returning 0xEF; then read DATA -> the read stalls until busy falls; busy lasts 16 cycles; 8 sck pulses; mosi sequence 1,0,0,1,1,1,1,1; the DATA read returns 0xEF; ss=0 throughout.
- DIV=3, DATA=0xA5 -> sck period 8 clk, busy for 64 clk; poll STATUS back-to-back without stall -> reads 0x01 then 0x00; miso sampled exactly on sck rising edges.
- Issue a CTRL write (value 0) while busy -> s_wb_stall=1 until busy=0; ss stays 0 through the last sck falling edge, then goes 1 one cycle after the CTRL write is acked.
- Assert sreset at the 4th sck rising edge -> next cycle sck=0, ss=1, busy=0, no ack; a following transfer of 0x3C completes normally.
- Write 0x55 to address 0x04 and 0x80 -> acked; no register changes; reads of those addresses return 0x00.

Source files
------------

// File: rtl/wb_spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// wb_spi_flash_pkg : register map, state encoding and status bit for the flash ctrl
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package wb_spi_flash_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter : mode-0 SPI byte engine, MSB first, SCK half-period = div+1 clk
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_byte_shifter
  import wb_spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       sreset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       mosi
);

  spi_state_t r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_div;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_falls;

  // mosi is the top of the tx register; the last falling edge skips the shift
  // so bit0 stays on the line until the next load.
  assign mosi = r_tx[7];

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      rx_byte <= 8'h00;
      sck     <= 1'b0;
      r_cnt   <= 8'h00;
      r_div   <= 8'h00;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_falls <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            busy    <= 1'b1;
            r_tx    <= tx_byte;
            r_div   <= div;
            r_cnt   <= 8'h00;
            r_falls <= 3'd0;
            sck     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == r_div) begin
            r_cnt <= 8'h00;
            if (!sck) begin
              sck  <= 1'b1;
              r_rx <= {r_rx[6:0], miso};
            end else begin
              sck <= 1'b0;
              if (r_falls == 3'd7) begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
                rx_byte <= r_rx;
              end else begin
                r_tx    <= {r_tx[6:0], 1'b0};
                r_falls <= r_falls + 3'd1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_spi_flash_ctrl.sv
// -----------------------------------------------------------------------------
// wb_spi_flash_ctrl : pipelined Wishbone register front-end for the config SPI flash
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_spi_flash_ctrl
  import wb_spi_flash_pkg::*;
#(
  parameter int         ADDR_BITS    = 8,
  parameter logic [7:0] CLKDIV_RESET = 8'd1
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic [ADDR_BITS-1:0] s_wb_addr,
  input  logic [7:0]           s_wb_dat_m2s,
  output logic [7:0]           s_wb_dat_s2m,
  input  logic                 s_wb_we,
  input  logic                 s_wb_sel,
  input  logic                 s_wb_stb,
  input  logic                 s_wb_cyc,
  output logic                 s_wb_ack,
  output logic                 s_wb_stall,
  output logic                 sck,
  output logic                 ss,
  input  logic                 miso,
  output logic                 mosi
);

  logic       w_hit;
  logic [1:0] w_reg;
  logic       w_accept;
  logic       w_start;
  logic       w_busy;
  logic [7:0] w_rx_byte;
  logic [7:0] w_rd_mux;
  logic       unused_sel;

  logic       r_ctrl;
  logic       r_ss;
  logic       r_ack;
  logic [7:0] r_div;
  logic [7:0] r_dat;

  assign unused_sel = s_wb_sel;

  assign w_hit = ((s_wb_addr >> 2) == '0);
  assign w_reg = s_wb_addr[1:0];

  // STATUS reads and unmapped addresses pass while busy so software can poll.
  assign s_wb_stall = w_busy & w_hit &
                      (s_wb_we ? (w_reg != REG_STATUS) : (w_reg == REG_DATA));
  assign w_accept   = s_wb_cyc & s_wb_stb & ~s_wb_stall;
  assign w_start    = w_accept & s_wb_we & w_hit & (w_reg == REG_DATA);

  // A master that abandons the cycle never sees the pending ack.
  assign s_wb_ack     = r_ack & s_wb_cyc;
  assign s_wb_dat_s2m = r_dat;
  assign ss           = r_ss;

  always_comb begin
    w_rd_mux = 8'h00;
    if (w_hit) begin
      case (w_reg)
        REG_CTRL:   w_rd_mux[0] = r_ctrl;
        REG_DATA:   w_rd_mux = w_rx_byte;
        REG_STATUS: w_rd_mux[STATUS_BUSY_BIT] = w_busy;
        REG_DIV:    w_rd_mux = r_div;
        default:    w_rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_ctrl <= 1'b0;
      r_ss   <= 1'b1;
      r_ack  <= 1'b0;
      r_div  <= CLKDIV_RESET;
      r_dat  <= 8'h00;
    end else begin
      r_ack <= w_accept;
      r_ss  <= ~r_ctrl;
      if (w_accept) begin
        r_dat <= s_wb_we ? 8'h00 : w_rd_mux;
        if (s_wb_we && w_hit) begin
          if (w_reg == REG_CTRL) r_ctrl <= s_wb_dat_m2s[0];
          if (w_reg == REG_DIV)  r_div  <= s_wb_dat_m2s;
        end
      end
    end
  end

  spi_byte_shifter u_shifter (
    .clk     (clk),
    .sreset  (sreset),
    .start   (w_start),
    .tx_byte (s_wb_dat_m2s),
    .div     (r_div),
    .miso    (miso),
    .busy    (w_busy),
    .rx_byte (w_rx_byte),
    .sck     (sck),
    .mosi    (mosi)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_spi_flash_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_spi_flash_ctrl : directed bench with a transaction-timing model of the flash ctrl
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wb_spi_flash_ctrl;

  logic       clk;
  logic       sreset;
  logic [7:0] addr;
  logic [7:0] dat_m2s;
  logic [7:0] dat_s2m;
  logic       we, sel, stb, cyc;
  logic       ack, stall;
  logic       sck, ss, miso, mosi;

  int n_cmp = 0;
  int n_bad = 0;

  wb_spi_flash_ctrl #(.ADDR_BITS(8), .CLKDIV_RESET(8'd1)) dut (
    .clk          (clk),
    .sreset       (sreset),
    .s_wb_addr    (addr),
    .s_wb_dat_m2s (dat_m2s),
    .s_wb_dat_s2m (dat_s2m),
    .s_wb_we      (we),
    .s_wb_sel     (sel),
    .s_wb_stb     (stb),
    .s_wb_cyc     (cyc),
    .s_wb_ack     (ack),
    .s_wb_stall   (stall),
    .sck          (sck),
    .ss           (ss),
    .miso         (miso),
    .mosi         (mosi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transfer timing is computed from elapsed cycles: half-period index
  // h = t/(div+1) gives sck = h odd and mosi = tx[7 - h/2].
  logic       m_valid = 1'b0;
  logic       m_active, m_ctrl, m_ss, m_ack, m_mosi_hold;
  logic [7:0] m_div_reg, m_rx, m_dat, m_tx, m_flash;
  int         m_t, m_div;
  logic [7:0] flash_byte;

  always @(negedge clk) begin : model
    int h, rises;
    logic e_sck, e_mosi, e_ack, e_stall, hit, acc;
    logic [1:0] a2;
    logic [7:0] nd;
    hit     = ((addr >> 2) == 8'd0);
    a2      = addr[1:0];
    h       = m_active ? m_t / (m_div + 1) : 0;
    e_sck   = m_active ? h[0] : 1'b0;
    e_mosi  = m_active ? m_tx[7 - h/2] : m_mosi_hold;
    e_stall = m_active && hit && (we ? (a2 != 2'd2) : (a2 == 2'd1));
    e_ack   = m_ack && cyc;
    if (m_valid) begin
      chk("ack", {7'b0, ack}, {7'b0, e_ack});
      chk("stall", {7'b0, stall}, {7'b0, e_stall});
      chk("sck", {7'b0, sck}, {7'b0, e_sck});
      chk("mosi", {7'b0, mosi}, {7'b0, e_mosi});
      chk("ss", {7'b0, ss}, {7'b0, m_ss});
      if (e_ack) chk("rdata", dat_s2m, m_dat);
    end
    // flash presents the next bit after each rising edge it has seen
    rises = (h + 1) / 2;
    miso  = (m_active && rises < 8) ? m_flash[7 - rises] : 1'b0;
    if (sreset) begin
      m_valid = 1'b1; m_active = 1'b0; m_ctrl = 1'b0; m_ss = 1'b1; m_ack = 1'b0;
      m_mosi_hold = 1'b0; m_div_reg = 8'd1; m_rx = 8'h00; m_dat = 8'h00;
      m_tx = 8'h00; m_flash = 8'h00; m_t = 0; m_div = 0;
    end else begin
      acc = cyc && stb && !e_stall;
      nd  = 8'h00;
      if (acc && !we && hit) begin
        case (a2)
          2'd0: nd = {7'b0, m_ctrl};
          2'd1: nd = m_rx;
          2'd2: nd = {7'b0, m_active};
          default: nd = m_div_reg;
        endcase
      end
      m_ss = !m_ctrl;
      if (m_active) begin
        m_t++;
        if (m_t == 16 * (m_div + 1)) begin
          m_active = 1'b0; m_rx = m_flash; m_mosi_hold = m_tx[0];
        end
      end
      if (acc && we && hit) begin
        case (a2)
          2'd0: m_ctrl = dat_m2s[0];
          2'd1: begin
            m_active = 1'b1; m_t = 0; m_div = int'(m_div_reg);
            m_tx = dat_m2s; m_flash = flash_byte;
          end
          2'd3: m_div_reg = dat_m2s;
          default: ;
        endcase
      end
      m_ack = acc;
      if (acc) m_dat = nd;
    end
  end

  // sck rising-edge monitor: counts pulses and captures mosi at each rise
  int         mon_rises = 0;
  logic [7:0] mon_cap = 8'h00;
  logic       mon_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (sck === 1'b1 && mon_prev === 1'b0) begin
      mon_rises++;
      mon_cap = {mon_cap[6:0], mosi};
    end
    mon_prev = sck;
  end

  // ---------------- stimulus ----------------
  task automatic wb_op(input logic [7:0] a, input logic w, input logic [7:0] d,
                       output logic [7:0] rd, output int nst);
    nst = 0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat_m2s = d;
    @(negedge clk);
    while (stall === 1'b1 && nst < 5000) begin
      nst++;
      @(negedge clk);
    end
    if (stall !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: stall=%b required 0", stall);
    end
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rd = dat_s2m;
    chk("ack_one_cycle", {7'b0, ack}, 8'h01);
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rd, first, last;
    int nst, base, n;
    logic got_first;
    sreset = 1'b1; addr = 8'h00; dat_m2s = 8'h00; we = 1'b0; sel = 1'b1;
    stb = 1'b0; cyc = 1'b0; flash_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1 sreset = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_ss", {7'b0, ss}, 8'h01);
    chk("rst_sck", {7'b0, sck}, 8'h00);
    @(posedge clk); #1;
    wb_op(8'h00, 1'b0, 8'h00, rd, nst); chk("rst_ctrl", rd, 8'h00);
    wb_op(8'h01, 1'b0, 8'h00, rd, nst); chk("rst_data", rd, 8'h00);
    wb_op(8'h02, 1'b0, 8'h00, rd, nst); chk("rst_status", rd, 8'h00);
    wb_op(8'h03, 1'b0, 8'h00, rd, nst); chk("rst_div", rd, 8'h01);

    // JEDEC-style byte at DIV=0
    wb_op(8'h00, 1'b1, 8'h01, rd, nst);
    wb_op(8'h03, 1'b1, 8'h00, rd, nst);
    flash_byte = 8'hEF; base = mon_rises;
    wb_op(8'h01, 1'b1, 8'h9F, rd, nst);
    wb_op(8'h01, 1'b0, 8'h00, rd, nst);
    chk("div0_read_stall", 8'(nst), 8'd15);
    chk("div0_rx", rd, 8'hEF);
    chk("div0_pulses", 8'(mon_rises - base), 8'd8);
    chk("div0_mosi_seq", mon_cap, 8'h9F);

    // DIV=3 with back-to-back STATUS polling
    wb_op(8'h03, 1'b1, 8'h03, rd, nst);
    flash_byte = 8'h5A; base = mon_rises;
    wb_op(8'h01, 1'b1, 8'hA5, rd, nst);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h02;
    nst = 0; got_first = 1'b0; first = 8'hFF; last = 8'hFF;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stall) nst++;
      if (ack) begin
        if (!got_first) begin first = dat_s2m; got_first = 1'b1; end
        last = dat_s2m;
      end
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("poll_no_stall", 8'(nst), 8'd0);
    chk("poll_first", first, 8'h01);
    chk("poll_last", last, 8'h00);
    chk("div3_pulses", 8'(mon_rises - base), 8'd8);
    chk("div3_mosi_seq", mon_cap, 8'hA5);
    wb_op(8'h01, 1'b0, 8'h00, rd, nst); chk("div3_rx", rd, 8'h5A);

    // CTRL write while busy stalls until the byte finishes
    wb_op(8'h03, 1'b1, 8'h01, rd, nst);
    flash_byte = 8'h12;
    wb_op(8'h01, 1'b1, 8'h81, rd, nst);
    wb_op(8'h00, 1'b1, 8'h00, rd, nst);
    chk("ctrl_stall_cycles", 8'(nst), 8'd31);
    @(negedge clk);
    chk("ss_released", {7'b0, ss}, 8'h01);
    @(posedge clk); #1;

    // abandoned cycle: ack must not appear
    wb_op(8'h00, 1'b1, 8'h01, rd, nst);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h02;
    @(negedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("ack_suppressed", {7'b0, ack}, 8'h00);
    @(posedge clk); #1;

    // reset mid-transfer, with a request presented during reset
    flash_byte = 8'h96; base = mon_rises;
    wb_op(8'h01, 1'b1, 8'hC3, rd, nst);
    n = 0;
    while ((mon_rises - base) < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fourth_rise_seen", 8'((mon_rises - base) >= 4), 8'h01);
    @(posedge clk); #1;
    sreset = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h02;
    @(posedge clk); #1;
    sreset = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_sck", {7'b0, sck}, 8'h00);
    chk("abort_ss", {7'b0, ss}, 8'h01);
    chk("abort_no_ack", {7'b0, ack}, 8'h00);
    @(posedge clk); #1;
    wb_op(8'h02, 1'b0, 8'h00, rd, nst); chk("abort_status", rd, 8'h00);
    wb_op(8'h03, 1'b0, 8'h00, rd, nst); chk("abort_div", rd, 8'h01);
    wb_op(8'h00, 1'b0, 8'h00, rd, nst); chk("abort_ctrl", rd, 8'h00);
    wb_op(8'h00, 1'b1, 8'h01, rd, nst);
    flash_byte = 8'hC3; base = mon_rises;
    wb_op(8'h01, 1'b1, 8'h3C, rd, nst);
    wb_op(8'h01, 1'b0, 8'h00, rd, nst);
    chk("post_abort_rx", rd, 8'hC3);
    chk("post_abort_pulses", 8'(mon_rises - base), 8'd8);
    chk("post_abort_mosi_seq", mon_cap, 8'h3C);

    // unmapped addresses
    wb_op(8'h04, 1'b1, 8'h55, rd, nst);
    wb_op(8'h80, 1'b1, 8'h55, rd, nst);
    wb_op(8'h04, 1'b0, 8'h00, rd, nst); chk("unmapped_04", rd, 8'h00);
    wb_op(8'h80, 1'b0, 8'h00, rd, nst); chk("unmapped_80", rd, 8'h00);
    wb_op(8'h00, 1'b0, 8'h00, rd, nst); chk("ctrl_kept", rd, 8'h01);
    wb_op(8'h03, 1'b0, 8'h00, rd, nst); chk("div_kept", rd, 8'h01);
    wb_op(8'h01, 1'b0, 8'h00, rd, nst); chk("data_kept", rd, 8'hC3);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
